// File: rtl/memory_bus_if.sv
// Word-memory bus between occupancy-grid clients and the grid memory server.
// The server forwards the clock onto clk and returns registered read data on r_data.
interface memory_bus #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  clk;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] r_data;

    modport server (
        output clk,
        output r_data,
        input  we,
        input  addr,
        input  w_data
    );

    modport client (
        input  clk,
        input  r_data,
        output we,
        output addr,
        output w_data
    );
endinterface

// File: rtl/grid_memory_server.sv
// Single-port word RAM behind memory_bus: one-cycle registered read-first reads, synchronous
// writes. Define GRID_MEMORY_SERVER_CLEAR_EN to compile in the array clear sweep.
module grid_memory_server #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    memory_bus.server   mem,
    input  logic        init_req,
    output logic        init_busy,
    output logic        init_done,
    output logic [31:0] write_count
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef enum logic {StClear, StServe} state_e;

    logic [DATA_WIDTH-1:0] array_q [Depth];
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [31:0]           count_q, count_d;
    state_e                state_q;
    logic [ADDR_WIDTH-1:0] sweep_ptr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    assign mem.clk     = clk;
    assign mem.r_data  = r_data_q;
    assign write_count = count_q;

`ifdef GRID_MEMORY_SERVER_CLEAR_EN
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StClear;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        unique case (state_q)
            StClear: begin
                ptr_d = ptr_q + 1'b1;
                // Last word written: pointer wraps to 0 and the done pulse lines up with busy falling
                if (&ptr_q) begin
                    state_d = StServe;
                    done_d  = 1'b1;
                end
            end
            StServe: begin
                if (init_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            default: state_d = StServe;
        endcase
    end

    assign init_busy = (state_q == StClear);
    assign init_done = done_q;
    assign sweep_ptr = ptr_q;
`else
    logic unused_init_req;

    assign unused_init_req = init_req;
    assign state_q         = StServe;
    assign init_busy       = 1'b0;
    assign init_done       = 1'b0;
    assign sweep_ptr       = '0;
`endif

    // The sweep owns the write port; client writes are dropped and not counted while clearing
    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = mem.addr;
        wr_data  = mem.w_data;
        count_d  = count_q;
        r_data_d = '0;
        if (state_q == StClear) begin
            wr_en   = 1'b1;
            wr_addr = sweep_ptr;
            wr_data = INIT_VALUE;
        end else begin
            r_data_d = array_q[mem.addr];
            if (mem.we) begin
                wr_en   = 1'b1;
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            array_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q <= '0;
            count_q  <= '0;
        end else begin
            r_data_q <= r_data_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_grid_memory_server.sv
// Scoreboard bench for grid_memory_server (DATA_WIDTH=32, ADDR_WIDTH=4); follows the
// GRID_MEMORY_SERVER_CLEAR_EN setting of the build.
module tb_grid_memory_server;
    logic        clk;
    logic        rst_n;
    logic        init_req;
    logic        init_busy;
    logic        init_done;
    logic [31:0] write_count;

    memory_bus #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

    grid_memory_server #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(4),
        .INIT_VALUE(32'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (bus),
        .init_req   (init_req),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .write_count(write_count)
    );

    typedef struct {
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic        chk_drv;
    logic        chk_pipe;
    int          n_tests;
    int          n_fail;
    int unsigned wc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // A read flagged at edge N is compared against r_data after that edge
    always @(posedge clk) chk_pipe <= chk_drv;

    always @(negedge clk) begin
        exp_t x;
        if (chk_pipe) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got r_data %h, expected no pending read", bus.r_data);
            end else begin
                x = sb.pop_front();
                check(x.name, bus.r_data, x.val);
            end
        end
    end

    task automatic cyc(input logic w, input logic [3:0] a, input logic [31:0] d, input logic req,
                       input logic c, input logic [31:0] e, input string n);
        bus.we     = w;
        bus.addr   = a;
        bus.w_data = d;
        init_req   = req;
        chk_drv    = c;
        if (c) sb.push_back('{val: e, name: n});
        @(posedge clk);
        #1;
        bus.we   = 1'b0;
        init_req = 1'b0;
        chk_drv  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cyc(1'b1, a, d, 1'b0, 1'b0, 32'h0, "");
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
        cyc(1'b0, a, 32'h0, 1'b0, 1'b1, e, n);
    endtask

    task automatic wait_done(input int exp_edges, input string n);
        int k = 0;
        while (init_done !== 1'b1 && k < 64) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({n, "_len"}, k, exp_edges);
        check({n, "_busy_fall"}, {31'b0, init_busy}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        wc         = 0;
        rst_n      = 1'b0;
        init_req   = 1'b0;
        chk_drv    = 1'b0;
        bus.we     = 1'b0;
        bus.addr   = 4'h0;
        bus.w_data = 32'h0;
        #12;
        check("rst_r_data", bus.r_data, 32'h0);
        check("rst_done", {31'b0, init_done}, 32'h0);
        check("rst_count", write_count, 32'h0);
`ifdef GRID_MEMORY_SERVER_CLEAR_EN
        check("rst_busy", {31'b0, init_busy}, 32'h1);
`else
        check("rst_busy", {31'b0, init_busy}, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef GRID_MEMORY_SERVER_CLEAR_EN
        wait_done(16, "boot");
        rd(4'd0, 32'h0, "boot_read");
        check("boot_done_pulse", {31'b0, init_done}, 32'h0);
        for (int i = 1; i < 16; i++) rd(4'(i), 32'h0, "boot_read");
`else
        // Array is undefined at power-up: seed the words read before they are written
        wr(4'd3, 32'h0);
        wc++;
        check("first_cycle_write", write_count, wc);
        wr(4'd2, 32'h0);
        wc++;
`endif

        wr(4'd5, 32'hDEADBEEF);
        wc++;
        rd(4'd5, 32'hDEADBEEF, "read_after_write");
        check("count_after_write", write_count, wc);

        cyc(1'b1, 4'd3, 32'h1, 1'b0, 1'b1, 32'h0, "read_first_old");
        wc++;
        rd(4'd3, 32'h1, "read_first_new");

        rd(4'd2, 32'h0, "rmw_read0");
        wr(4'd2, 32'h0000_0080);
        rd(4'd2, 32'h0000_0080, "rmw_read1");
        wr(4'd2, 32'h0000_0280);
        wc += 2;
        rd(4'd2, 32'h0000_0280, "rmw_final");
        check("count_after_rmw", write_count, wc);

        rd(4'd5, 32'hDEADBEEF, "pipe_rd5");
        rd(4'd3, 32'h1, "pipe_rd3");
        rd(4'd2, 32'h0000_0280, "pipe_rd2");

`ifdef GRID_MEMORY_SERVER_CLEAR_EN
        // Request sweep with a coincident write; it counts, then gets cleared
        cyc(1'b1, 4'd9, 32'h55, 1'b1, 1'b0, 32'h0, "");
        wc++;
        check("req_busy", {31'b0, init_busy}, 32'h1);
        check("req_write_counted", write_count, wc);
        cyc(1'b0, 4'd5, 32'h0, 1'b0, 1'b0, 32'h0, "");
        cyc(1'b0, 4'd5, 32'h0, 1'b0, 1'b0, 32'h0, "");
        cyc(1'b1, 4'd4, 32'h1234, 1'b0, 1'b0, 32'h0, "");
        cyc(1'b0, 4'd5, 32'h0, 1'b1, 1'b0, 32'h0, "");
        check("sweep_write_dropped", write_count, wc);
        check("sweep_r_data_zero", bus.r_data, 32'h0);
        wait_done(12, "sweep");
        rd(4'd0, 32'h0, "sweep_read");
        check("sweep_done_pulse", {31'b0, init_done}, 32'h0);
        for (int i = 1; i < 16; i++) rd(4'(i), 32'h0, "sweep_read");
        check("count_after_sweep", write_count, wc);

        // Reset at sweep cycle 7
        cyc(1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h0, "");
        for (int i = 0; i < 7; i++) cyc(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0, "");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_count", write_count, 32'h0);
        check("midrst_busy", {31'b0, init_busy}, 32'h1);
        check("midrst_done", {31'b0, init_done}, 32'h0);
        check("midrst_r_data", bus.r_data, 32'h0);
        wc = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_done(16, "resweep");
        wr(4'd1, 32'hA5);
        wc++;
        check("resweep_done_pulse", {31'b0, init_done}, 32'h0);
        check("first_write_after_done", write_count, wc);
        rd(4'd1, 32'hA5, "resweep_read1");
`else
        cyc(1'b1, 4'd6, 32'h77, 1'b1, 1'b0, 32'h0, "");
        wc++;
        check("req_ignored_busy", {31'b0, init_busy}, 32'h0);
        rd(4'd6, 32'h77, "req_ignored_data");
        check("req_ignored_count", write_count, wc);
`endif

        cyc(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0, "");
        cyc(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0, "");
        check("sb_drained", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
